pulse_conditioner: RTL and testbench
====================================

# pulse_conditioner

Input conditioning stage directly upstream of the high-period pulse counter. It synchronizes an asynchronous raw pulse into the SYS_CLK domain and rejects glitches shorter than a programmable number of cycles. It delivers a clean, registered PULSE level plus one-cycle RISE/FALL strobes to the counter. It also counts rejected glitches for diagnostics.

## Interface
- SYNC_STAGES, default 2: synchronizer depth; legal range 2..4.
- FILT_CYCLES, default 3: consecutive equal synchronized samples required to accept a level change; legal range 1..15.
- CNT_W, default 8: width of the glitch counter.

Ports:
- SYS_CLK  in  1  system clock; the block's only clock.
- A_RESET_N  in  1  asynchronous, active-low reset.
- PULSE_RAW  in  1  asynchronous raw pulse input.
- CLR_STATS  in  1  synchronous clear of GLITCH_CNT.
- PULSE  out  1  filtered, registered pulse level, fed to the pulse counter.
- RISE  out  1  one-cycle strobe when PULSE goes 0->1.
- FALL  out  1  one-cycle strobe when PULSE goes 1->0.
- GLITCH_CNT  out  CNT_W  saturating count of rejected transitions.

## Operation
- Synchronizer: SYNC_STAGES flops, all reset to 0. Its output is sample s.
- The FSM has four states: LOW, RISE_PEND, HIGH and FALL_PEND. A filter counter cnt of width $clog2(FILT_CYCLES+1) supports it.
- LOW:
  - s=1 with FILT_CYCLES=1 -> go directly to HIGH.
  - Otherwise, s=1 -> go to RISE_PEND with cnt=1.
- RISE_PEND:
  - s=1 with cnt==FILT_CYCLES-1 -> go to HIGH, with PULSE<=1 and RISE<=1.
  - s=1 otherwise -> cnt++.
  - s=0 -> go to LOW, with cnt=0 and a glitch event.
- HIGH and FALL_PEND mirror the above with polarity inverted. Acceptance gives PULSE<=0 and FALL<=1.
- RISE and FALL are high for exactly one cycle. They are never both high in the same cycle.
- A glitch event increments GLITCH_CNT, which saturates at 2^CNT_W-1.
- If CLR_STATS and a glitch event occur in the same cycle, CLR_STATS wins and GLITCH_CNT becomes 0.
- All outputs are driven directly from flops.

## Timing
- Reset values:
  - PULSE=0, RISE=0, FALL=0 and GLITCH_CNT=0.
  - The state is LOW, cnt=0 and the synchronizer flops are 0.
- Reset assertion takes effect asynchronously. If it arrives while PULSE=1, PULSE drops immediately and no FALL strobe is generated.
- Latency from the first SYS_CLK edge that samples PULSE_RAW=1 to PULSE=1 is SYNC_STAGES+FILT_CYCLES edges. The same latency applies to the falling direction.
- A raw level held for fewer than FILT_CYCLES synchronized samples never reaches PULSE. The minimum accepted width is FILT_CYCLES cycles.
- After reset release, if PULSE_RAW is already 1, it is qualified as a normal rise. RISE is generated, and the counter sees a fresh pulse.
- In the PEND states, cnt never exceeds FILT_CYCLES-1. It is 0 in the stable states.

## Configuration
- Macro PULSE_COND_GLITCH_CNT_EN.
- When defined, the glitch counter and CLR_STATS logic are compiled in as specified above.
- When undefined, GLITCH_CNT is tied to 0 and CLR_STATS is ignored. The filtering behaviour is identical in both builds.

## Structure
- Package pulse_cond_pkg contains:
  - the typedef enum for the states (LOW, RISE_PEND, HIGH, FALL_PEND);
  - the default constants for SYNC_STAGES, FILT_CYCLES and CNT_W;
  - a localparam function for the width of cnt.
- Sub-module sync_ff: an N-stage, reset-to-0 synchronizer parameterized by SYNC_STAGES. It is instantiated once, on PULSE_RAW.

## Test plan
Common setup: SYNC_STAGES=2, FILT_CYCLES=3, 100 ns clock.

1. Hold A_RESET_N=0 for 100 ns, then release with PULSE_RAW=0 for 1 µs.
   - PULSE, RISE and FALL stay 0, and GLITCH_CNT=0.
2. Raise PULSE_RAW and hold it for 800 ns.
   - PULSE rises exactly 5 edges after the first edge that samples 1.
   - RISE is high in exactly that cycle.
   - After PULSE_RAW drops, PULSE falls 5 edges later with a single FALL strobe.
3. Pulse PULSE_RAW high for 200 ns (2 cycles) from LOW.
   - PULSE stays 0 throughout and GLITCH_CNT=1.
4. While in HIGH, drop PULSE_RAW for 100 ns.
   - PULSE stays 1, there is no FALL, and GLITCH_CNT increments by 1.
5. Build with CNT_W=2 and apply 5 glitches.
   - GLITCH_CNT saturates at 3.
   - Asserting CLR_STATS in the same cycle as a 6th glitch gives GLITCH_CNT=0.
   - Built without PULSE_COND_GLITCH_CNT_EN, GLITCH_CNT stays 0 throughout.
6. Assert A_RESET_N=0 mid-cycle while PULSE=1 and PULSE_RAW=1.
   - PULSE drops before the next clock edge, with no FALL strobe.
   - After release, RISE occurs 5 edges later and PULSE returns to 1.

Source files
------------

// File: rtl/pulse_cond_pkg.sv
// pulse_cond_pkg: shared definitions for the pulse_conditioner slice.
//   - state_e         : filter FSM states (LOW, RISE_PEND, HIGH, FALL_PEND)
//   - *_DEF constants : default SYNC_STAGES / FILT_CYCLES / CNT_W
//   - filt_cnt_width(): width of the filter counter for a given FILT_CYCLES
package pulse_cond_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 3;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_e;

  // The counter must hold values up to FILT_CYCLES-1; sizing it for
  // FILT_CYCLES+1 values keeps it at least one bit wide when FILT_CYCLES=1.
  function automatic int filt_cnt_width(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/pulse_conditioner_sync_ff.sv
// sync_ff: N-stage reset-to-0 synchronizer for a single asynchronous bit.
// Parameters:
//   STAGES : number of flops in the chain (2..4)
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset, clears every stage
//   d_i   in  asynchronous input bit
//   q_o   out synchronized bit (output of the last stage)
module sync_ff
  import pulse_cond_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples the value its neighbour held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronizes an asynchronous raw pulse into SYS_CLK,
// rejects glitches shorter than FILT_CYCLES synchronized samples, and emits a
// registered level plus one-cycle RISE/FALL strobes for the pulse counter.
// Optional feature: define PULSE_COND_GLITCH_CNT_EN to build the saturating
// glitch counter and CLR_STATS; otherwise GLITCH_CNT is tied to 0.
// Parameters:
//   SYNC_STAGES : synchronizer depth (2..4)
//   FILT_CYCLES : equal samples needed to accept a level change (1..15)
//   CNT_W       : glitch counter width
// Ports:
//   SYS_CLK    in  clock
//   A_RESET_N  in  asynchronous active-low reset
//   PULSE_RAW  in  asynchronous raw pulse
//   CLR_STATS  in  synchronous clear of GLITCH_CNT (wins over a glitch)
//   PULSE      out filtered registered level
//   RISE       out one-cycle strobe on PULSE 0->1
//   FALL       out one-cycle strobe on PULSE 1->0
//   GLITCH_CNT out saturating count of rejected transitions
module pulse_conditioner
  import pulse_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             SYS_CLK,
  input  logic             A_RESET_N,
  input  logic             PULSE_RAW,
  input  logic             CLR_STATS,
  output logic             PULSE,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] GLITCH_CNT
);

  localparam int             CW       = filt_cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYCLES - 1);
  localparam bit             FILT_ONE = (FILT_CYCLES == 1);

  logic          s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          glitch;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (SYS_CLK),
    .rst_n(A_RESET_N),
    .d_i  (PULSE_RAW),
    .q_o  (s)
  );

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    glitch  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          if (FILT_ONE) begin
            state_d = HIGH;
            pulse_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = RISE_PEND;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RISE_PEND: begin
        if (s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            pulse_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Level fell back before qualifying: a rejected rising glitch.
          state_d = LOW;
          cnt_d   = '0;
          glitch  = 1'b1;
        end
      end
      HIGH: begin
        if (!s) begin
          if (FILT_ONE) begin
            state_d = LOW;
            pulse_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = FALL_PEND;
            cnt_d   = CNT_ONE;
          end
        end
      end
      FALL_PEND: begin
        if (!s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            pulse_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = HIGH;
          cnt_d   = '0;
          glitch  = 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Asynchronous reset clears PULSE immediately; the strobes are cleared too,
  // so a reset taken while high never produces a FALL.
  always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      state_q <= LOW;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign PULSE = pulse_q;
  assign RISE  = rise_q;
  assign FALL  = fall_q;

`ifdef PULSE_COND_GLITCH_CNT_EN
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (CLR_STATS) begin
      gcnt_d = '0;
    end else if (glitch && (gcnt_q != {CNT_W{1'b1}})) begin
      gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign GLITCH_CNT = gcnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{CLR_STATS, glitch};
  assign GLITCH_CNT   = '0;
`endif

endmodule

// File: tb/tb_pulse_conditioner.sv
// tb_pulse_conditioner: self-checking bench for pulse_conditioner.
// Two instances share all inputs: one with the default CNT_W=8 and one with
// CNT_W=2 to exercise saturation. A segment table covers the directed cases,
// hand sequences cover the same-cycle clear and mid-cycle reset, and a random
// phase is compared cycle by cycle against a sample-window reference model.
module tb_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int FILT = 3;
`ifdef PULSE_COND_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       a_reset_n;
  logic       pulse_raw;
  logic       clr_stats;
  logic       pulse, rise, fall;
  logic [7:0] gc8;
  logic       pulse2, rise2, fall2;
  logic [1:0] gc2;

  int tests = 0;
  int fails = 0;

  always #50 sys_clk = ~sys_clk;

  pulse_conditioner #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(8)) dut (
    .SYS_CLK   (sys_clk),
    .A_RESET_N (a_reset_n),
    .PULSE_RAW (pulse_raw),
    .CLR_STATS (clr_stats),
    .PULSE     (pulse),
    .RISE      (rise),
    .FALL      (fall),
    .GLITCH_CNT(gc8)
  );

  pulse_conditioner #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(2)) dut_sat (
    .SYS_CLK   (sys_clk),
    .A_RESET_N (a_reset_n),
    .PULSE_RAW (pulse_raw),
    .CLR_STATS (clr_stats),
    .PULSE     (pulse2),
    .RISE      (rise2),
    .FALL      (fall2),
    .GLITCH_CNT(gc2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PULSE flips once the last FILT synchronized samples all
  // disagree with it; a disagreement run that ends early is a glitch.
  bit raw_hist[$];
  bit s_win[$];
  bit m_pulse, m_rise, m_fall, m_prev_s;
  int m_g8, m_g2;

  task automatic model_reset();
    raw_hist.delete();
    s_win.delete();
    m_pulse  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_prev_s = 1'b0;
    m_g8     = 0;
    m_g2     = 0;
  endtask

  task automatic model_edge(input bit raw, input bit clr);
    bit s;
    bit all_diff;
    bit glitch;
    s = (raw_hist.size() == SYNC) ? raw_hist[0] : 1'b0;
    raw_hist.push_back(raw);
    if (raw_hist.size() > SYNC) void'(raw_hist.pop_front());
    s_win.push_back(s);
    if (s_win.size() > FILT) void'(s_win.pop_front());
    all_diff = (s_win.size() == FILT);
    foreach (s_win[i]) if (s_win[i] == m_pulse) all_diff = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    glitch = 1'b0;
    if (all_diff) begin
      m_pulse = ~m_pulse;
      m_rise  = m_pulse;
      m_fall  = ~m_pulse;
    end else if (s == m_pulse && m_prev_s != m_pulse) begin
      glitch = 1'b1;
    end
    m_prev_s = s;
    if (clr) begin
      m_g8 = 0;
      m_g2 = 0;
    end else if (glitch) begin
      m_g8 = (m_g8 < 255) ? m_g8 + 1 : 255;
      m_g2 = (m_g2 < 3) ? m_g2 + 1 : 3;
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (a_reset_n) model_edge(pulse_raw, clr_stats);
    check("outs", {29'd0, pulse, rise, fall}, {29'd0, m_pulse, m_rise, m_fall});
    check("outs_w2", {29'd0, pulse2, rise2, fall2}, {29'd0, m_pulse, m_rise, m_fall});
    check("gc8", {24'd0, gc8}, GC_EN ? 32'(m_g8) : 32'd0);
    check("gc2", {30'd0, gc2}, GC_EN ? 32'(m_g2) : 32'd0);
    check("rise_fall_excl", {31'd0, rise & fall}, 32'd0);
  endtask

  typedef struct {
    bit raw;
    bit clr;
    int cycles;
    bit exp_pulse;
    int exp_rises;
    int exp_falls;
    int exp_g8;
    int exp_g2;
  } seg_t;

  seg_t segs[$];

  initial begin
    int r, f, rise_at;

    // Directed segments: expected values derived by hand for SYNC=2, FILT=3.
    segs.push_back('{0, 0, 10, 0, 0, 0, 0, 0}); // idle after reset
    segs.push_back('{1, 0,  8, 1, 1, 0, 0, 0}); // clean rise, 5-edge latency
    segs.push_back('{0, 0,  8, 0, 0, 1, 0, 0}); // clean fall
    segs.push_back('{1, 0,  2, 0, 0, 0, 0, 0}); // 2-cycle high glitch...
    segs.push_back('{0, 0,  8, 0, 0, 0, 1, 1}); // ...rejected here
    segs.push_back('{1, 0,  8, 1, 1, 0, 1, 1});
    segs.push_back('{0, 0,  1, 1, 0, 0, 1, 1}); // 1-cycle low glitch in HIGH...
    segs.push_back('{1, 0,  8, 1, 0, 0, 2, 2}); // ...rejected, no FALL
    segs.push_back('{0, 0,  3, 1, 0, 0, 2, 2}); // exactly FILT cycles low
    segs.push_back('{1, 0,  8, 1, 1, 1, 2, 2}); // accepted fall, then rise
    segs.push_back('{0, 0,  8, 0, 0, 1, 2, 2});
    for (int k = 0; k < 5; k++) begin          // five more glitches: sat at 3
      segs.push_back('{1, 0, 2, 0, 0, 0, 2 + k, (2 + k > 3) ? 3 : 2 + k});
      segs.push_back('{0, 0, 4, 0, 0, 0, 3 + k, (3 + k > 3) ? 3 : 3 + k});
    end
    segs.push_back('{1, 0, 2, 0, 0, 0, 7, 3});
    segs.push_back('{0, 1, 4, 0, 0, 0, 0, 0}); // clear held over 6th glitch

    a_reset_n = 1'b0;
    pulse_raw = 1'b0;
    clr_stats = 1'b0;
    model_reset();
    #1;
    check("reset_state", {21'd0, pulse, rise, fall, gc8}, 32'd0);
    #99;
    a_reset_n = 1'b1;

    foreach (segs[i]) begin
      pulse_raw = segs[i].raw;
      clr_stats = segs[i].clr;
      r = 0;
      f = 0;
      for (int c = 0; c < segs[i].cycles; c++) begin
        step();
        r += int'(rise);
        f += int'(fall);
      end
      check($sformatf("seg%0d_pulse", i), {31'd0, pulse}, {31'd0, segs[i].exp_pulse});
      check($sformatf("seg%0d_rises", i), r, segs[i].exp_rises);
      check($sformatf("seg%0d_falls", i), f, segs[i].exp_falls);
      check($sformatf("seg%0d_gc8", i), {24'd0, gc8}, GC_EN ? segs[i].exp_g8 : 0);
      check($sformatf("seg%0d_gc2", i), {30'd0, gc2}, GC_EN ? segs[i].exp_g2 : 0);
    end
    clr_stats = 1'b0;

    // Same-cycle clear: build one glitch, then clear exactly on the next one.
    pulse_raw = 1'b1; step(); step();
    pulse_raw = 1'b0; step(); step(); step(); step();
    check("glitch_before_clr", {24'd0, gc8}, GC_EN ? 32'd1 : 32'd0);
    pulse_raw = 1'b1; step(); step();
    pulse_raw = 1'b0; step(); step();
    clr_stats = 1'b1; step();                  // glitch edge
    clr_stats = 1'b0; step();
    check("clr_same_cycle", {24'd0, gc8}, 32'd0);

    // Mid-cycle reset while high, then requalification of a held-high input.
    pulse_raw = 1'b1;
    repeat (8) step();
    check("pre_reset_high", {31'd0, pulse}, 32'd1);
    #20;
    a_reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_pulse", {29'd0, pulse, rise, fall}, 32'd0);
    repeat (2) step();
    @(negedge sys_clk);
    a_reset_n = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rise && rise_at == 0) rise_at = k;
    end
    check("post_reset_rise_edge", rise_at, 5);
    check("post_reset_pulse", {31'd0, pulse}, 32'd1);

    // Random bursts of varying width with occasional clears.
    for (int b = 0; b < 60; b++) begin
      pulse_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 6)) begin
        clr_stats = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    clr_stats = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
